// File: rtl/cpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared encodings for the multicycle ARM controller: FSM state type, ALU
// control codes, condition-field codes, mux-select constants and a helper
// that decodes the data-processing cmd field.
// No ports (package).
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_ORR = 3'b011,
        ALU_EOR = 3'b100
    } alu_ctl_t;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_t;

    // result_src
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // alu_src_b
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // imm_src
    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    // op field
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // data-processing cmd field
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    typedef struct packed {
        alu_ctl_t ctl;     // ALU operation for the execute cycle
        logic     known;   // cmd is one of the supported encodings
        logic     is_cmp;  // compare: flags only, no register writeback
        logic     is_mov;  // move: datapath passes src_b through the shifter
    } dp_dec_t;

    // Undefined encodings fall back to ADD with known=0 so that the
    // controller can suppress every write for them.
    function automatic dp_dec_t dp_decode(input logic [3:0] cmd);
        dp_dec_t d;
        d.ctl    = ALU_ADD;
        d.known  = 1'b1;
        d.is_cmp = 1'b0;
        d.is_mov = 1'b0;
        case (cmd)
            CMD_ADD: d.ctl = ALU_ADD;
            CMD_SUB: d.ctl = ALU_SUB;
            CMD_CMP: begin
                d.ctl    = ALU_SUB;
                d.is_cmp = 1'b1;
            end
            CMD_AND: d.ctl = ALU_AND;
            CMD_ORR: d.ctl = ALU_ORR;
            CMD_EOR: d.ctl = ALU_EOR;
            CMD_MOV: begin
                d.ctl    = ALU_ADD;
                d.is_mov = 1'b1;
            end
            default: d.known = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/multicycle_controller_cond_unit.sv
// ---------------------------------------------------------------------------
// cond_unit
// Holds the NZCV flags register and evaluates an instruction's cond field
// against it (combinationally, on the current register contents).
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset (clears flags)
//   i_cond       cond field of the instruction register
//   i_alu_flags  NZCV produced by the ALU this cycle
//   i_flag_we    load i_alu_flags into the flags register on this edge
//   o_flags      NZCV register
//   o_cond_ex    1 when the condition holds for the current flags
// ---------------------------------------------------------------------------
module cond_unit
    import cpu_ctrl_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_cond,
    input  logic [3:0] i_alu_flags,
    input  logic       i_flag_we,
    output logic [3:0] o_flags,
    output logic       o_cond_ex
);

    logic [3:0] r_flags;
    logic       w_n;
    logic       w_z;
    logic       w_c;
    logic       w_v;

    assign w_n     = r_flags[3];
    assign w_z     = r_flags[2];
    assign w_c     = r_flags[1];
    assign w_v     = r_flags[0];
    assign o_flags = r_flags;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_flags <= 4'b0000;
        end else if (i_flag_we) begin
            r_flags <= i_alu_flags;
        end
    end

    always_comb begin
        o_cond_ex = 1'b0;
        case (cond_t'(i_cond))
            COND_EQ: o_cond_ex = w_z;
            COND_NE: o_cond_ex = ~w_z;
            COND_CS: o_cond_ex = w_c;
            COND_CC: o_cond_ex = ~w_c;
            COND_MI: o_cond_ex = w_n;
            COND_PL: o_cond_ex = ~w_n;
            COND_VS: o_cond_ex = w_v;
            COND_VC: o_cond_ex = ~w_v;
            COND_HI: o_cond_ex = w_c & ~w_z;
            COND_LS: o_cond_ex = ~w_c | w_z;
            COND_GE: o_cond_ex = (w_n == w_v);
            COND_LT: o_cond_ex = (w_n != w_v);
            COND_GT: o_cond_ex = ~w_z & (w_n == w_v);
            COND_LE: o_cond_ex = w_z | (w_n != w_v);
            COND_AL: o_cond_ex = 1'b1;
            default: o_cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
// Moore FSM sequencing the shared-memory multicycle ARM datapath through
// FETCH / DECODE / MEMADR / MEMREAD / MEMWB / MEMWRITE / EXECUTER /
// EXECUTEI / ALUWB / BRANCH. Decodes the IR, gates writes with the
// condition check and drives every mux select and write enable.
// Optional build macro: CTRL_MEM_WAIT_EN adds the mem_ready handshake;
// without it memory is treated as always ready.
// Ports:
//   clk         clock, rising edge
//   reset       asynchronous active-low reset
//   instr       IR contents (cond, op, funct, rd)
//   alu_flags   NZCV from the ALU, current cycle
//   mem_ready   memory handshake (CTRL_MEM_WAIT_EN only)
//   pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
//   alu_src_a, alu_src_b, imm_src, reg_src, alu_ctl, shift
//               datapath controls
//   carry       C bit of the flags register
//   flags       NZCV register
// ---------------------------------------------------------------------------
module multicycle_controller
    import cpu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [3:0]  alu_flags,
`ifdef CTRL_MEM_WAIT_EN
    input  logic        mem_ready,
`endif
    output logic        pc_write,
    output logic        adr_src,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic [1:0]  result_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  imm_src,
    output logic [1:0]  reg_src,
    output logic [2:0]  alu_ctl,
    output logic        shift,
    output logic        carry,
    output logic [3:0]  flags
);

    state_t      r_state;
    logic        r_cond_ex;

    logic [3:0]  w_cond;
    logic [1:0]  w_op;
    logic [5:0]  w_funct;
    logic [3:0]  w_rd;
    logic        w_rd_pc;
    logic        w_mem_ready;
    logic        w_cond_ex;
    logic        w_flag_we;
    logic        w_dp_wr;
    dp_dec_t     w_dec;
    logic        w_unused_instr;

    assign w_cond  = instr[31:28];
    assign w_op    = instr[27:26];
    assign w_funct = instr[25:20];
    assign w_rd    = instr[15:12];
    assign w_rd_pc = (w_rd == 4'd15);
    assign w_dec   = dp_decode(w_funct[4:1]);

    // Rn and the immediate/shift fields are datapath concerns only.
    assign w_unused_instr = &{1'b0, instr[19:16], instr[11:0]};

`ifdef CTRL_MEM_WAIT_EN
    assign w_mem_ready = mem_ready;
`else
    assign w_mem_ready = 1'b1;
`endif

    // The condition is captured while leaving DECODE so that later cycles
    // of the same instruction see the pre-instruction flags even after
    // EXECUTE has updated the register (matters for ALUWB after CMP/ADDS).
    cond_unit u_cond (
        .i_clk       (clk),
        .i_rst_n     (reset),
        .i_cond      (w_cond),
        .i_alu_flags (alu_flags),
        .i_flag_we   (w_flag_we),
        .o_flags     (flags),
        .o_cond_ex   (w_cond_ex)
    );

    assign carry = flags[1];

    assign w_flag_we = ((r_state == S_EXECUTER) || (r_state == S_EXECUTEI)) &&
                       r_cond_ex && w_dec.known && (w_funct[0] || w_dec.is_cmp);

    // Register writeback for data-processing: not for CMP or unknown cmds.
    assign w_dp_wr = r_cond_ex & w_dec.known & ~w_dec.is_cmp;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_FETCH;
            r_cond_ex <= 1'b0;
        end else begin
            if (r_state == S_DECODE) begin
                r_cond_ex <= w_cond_ex;
            end
            case (r_state)
                S_FETCH: begin
                    if (w_mem_ready) r_state <= S_DECODE;
                end
                S_DECODE: begin
                    case (w_op)
                        OP_MEM:  r_state <= S_MEMADR;
                        OP_DP:   r_state <= w_funct[5] ? S_EXECUTEI : S_EXECUTER;
                        OP_BR:   r_state <= S_BRANCH;
                        default: r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR:   r_state <= w_funct[0] ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD: begin
                    if (w_mem_ready) r_state <= S_MEMWB;
                end
                S_MEMWB:    r_state <= S_FETCH;
                S_MEMWRITE: begin
                    if (w_mem_ready) r_state <= S_FETCH;
                end
                S_EXECUTER: r_state <= S_ALUWB;
                S_EXECUTEI: r_state <= S_ALUWB;
                S_ALUWB:    r_state <= S_FETCH;
                S_BRANCH:   r_state <= S_FETCH;
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        imm_src    = IMM_DP;
        reg_src    = 2'b00;
        alu_ctl    = ALU_ADD;
        shift      = 1'b0;
        case (r_state)
            S_FETCH: begin
                adr_src    = 1'b0;
                ir_write   = w_mem_ready;
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                alu_ctl    = ALU_ADD;
                result_src = RES_ALU;
                pc_write   = w_mem_ready;
            end
            S_DECODE: begin
                reg_src    = 2'b01;
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                alu_ctl    = ALU_ADD;
            end
            S_MEMADR: begin
                alu_src_b  = SRCB_IMM;
                imm_src    = IMM_MEM;
                reg_src    = 2'b10;
                alu_ctl    = w_funct[3] ? ALU_ADD : ALU_SUB;
            end
            S_MEMREAD: begin
                adr_src    = 1'b1;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = r_cond_ex;
                pc_write   = r_cond_ex & w_rd_pc;
            end
            S_MEMWRITE: begin
                adr_src    = 1'b1;
                mem_write  = r_cond_ex;
            end
            S_EXECUTER: begin
                alu_src_b  = SRCB_REG;
                alu_ctl    = w_dec.ctl;
                shift      = w_dec.is_mov;
            end
            S_EXECUTEI: begin
                alu_src_b  = SRCB_IMM;
                imm_src    = IMM_DP;
                alu_ctl    = w_dec.ctl;
                shift      = w_dec.is_mov;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = w_dp_wr;
                pc_write   = w_dp_wr & w_rd_pc;
            end
            S_BRANCH: begin
                reg_src    = 2'b01;
                alu_src_a  = 1'b0;
                alu_src_b  = SRCB_IMM;
                imm_src    = IMM_BR;
                alu_ctl    = ALU_ADD;
                result_src = RES_ALU;
                pc_write   = r_cond_ex;
            end
            default: ;
        endcase
        // No architectural writes may escape while reset is held.
        if (!reset) begin
            pc_write  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller: per-instruction behavioural model
// builds the expected cycle list; a monitor compares each cycle's outputs.
module tb_multicycle_controller;

    localparam int P_FLAGS  = 0;
    localparam int P_CARRY  = 4;
    localparam int P_SHIFT  = 5;
    localparam int P_ALU    = 6;
    localparam int P_REGSRC = 9;
    localparam int P_IMM    = 11;
    localparam int P_SRCB   = 13;
    localparam int P_SRCA   = 15;
    localparam int P_RES    = 16;
    localparam int P_RW     = 18;
    localparam int P_IRW    = 19;
    localparam int P_MW     = 20;
    localparam int P_ADR    = 21;
    localparam int P_PCW    = 22;

    typedef struct {
        logic [22:0] exp;
        logic [22:0] msk;
        logic        rdy;
        logic [31:0] ins;
        string       name;
    } cyc_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instr = 32'h0;
    logic [3:0]  alu_flags = 4'h0;
`ifdef CTRL_MEM_WAIT_EN
    logic        mem_ready = 1'b1;
`endif
    logic        pc_write, adr_src, mem_write, ir_write, reg_write;
    logic [1:0]  result_src, alu_src_b, imm_src, reg_src;
    logic        alu_src_a, shift, carry;
    logic [2:0]  alu_ctl;
    logic [3:0]  flags;

    cyc_t        plan[$];
    cyc_t        exp_q[$];
    cyc_t        mon_e;
    logic [22:0] got;
    logic [22:0] c_exp;
    logic [22:0] c_msk;
    logic [31:0] c_ins;
    logic [3:0]  m_flags = 4'h0;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .alu_flags  (alu_flags),
`ifdef CTRL_MEM_WAIT_EN
        .mem_ready  (mem_ready),
`endif
        .pc_write   (pc_write),
        .adr_src    (adr_src),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .imm_src    (imm_src),
        .reg_src    (reg_src),
        .alu_ctl    (alu_ctl),
        .shift      (shift),
        .carry      (carry),
        .flags      (flags)
    );

    // ---------------- reference model ----------------
    function automatic bit cond_holds(logic [3:0] c, logic [3:0] f);
        bit n = f[3], z = f[2], cy = f[1], v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void fld(int lsb, int w, int v);
        for (int i = 0; i < w; i++) begin
            c_exp[lsb+i] = v[i];
            c_msk[lsb+i] = 1'b1;
        end
    endfunction

    // Enables, shift, carry and flags are checked in every cycle.
    function automatic void begin_cycle();
        c_exp = '0;
        c_msk = '0;
        fld(P_FLAGS, 4, int'(m_flags));
        fld(P_CARRY, 1, int'(m_flags[1]));
        fld(P_SHIFT, 1, 0);
        fld(P_RW, 1, 0);
        fld(P_IRW, 1, 0);
        fld(P_MW, 1, 0);
        fld(P_PCW, 1, 0);
    endfunction

    function automatic void push_cycle(string nm, bit rdy);
        cyc_t c;
        c.exp  = c_exp;
        c.msk  = c_msk;
        c.rdy  = rdy;
        c.ins  = c_ins;
        c.name = nm;
        plan.push_back(c);
    endfunction

    function automatic void fetch_fields(bit rdy);
        fld(P_ADR, 1, 0);
        fld(P_SRCA, 1, 1);
        fld(P_SRCB, 2, 2);
        fld(P_ALU, 3, 0);
        fld(P_RES, 2, 2);
        fld(P_IRW, 1, int'(rdy));
        fld(P_PCW, 1, int'(rdy));
    endfunction

    function automatic void model_instr(logic [31:0] ins, logic [3:0] af, int fwait, int mwait);
        logic [1:0] op    = ins[27:26];
        logic [5:0] funct = ins[25:20];
        logic [3:0] cmd   = ins[24:21];
        bit         rdpc  = (ins[15:12] == 4'd15);
        bit         cex   = cond_holds(ins[31:28], m_flags);
        bit         known = 1'b1;
        bit         cmp   = (cmd == 4'b1010);
        int         ctl   = 0;
        c_ins = ins;
        for (int i = 0; i < fwait; i++) begin
            begin_cycle(); fetch_fields(1'b0); push_cycle("FETCH-wait", 1'b0);
        end
        begin_cycle(); fetch_fields(1'b1); push_cycle("FETCH", 1'b1);
        begin_cycle();
        fld(P_REGSRC, 2, 1); fld(P_SRCA, 1, 1); fld(P_SRCB, 2, 2); fld(P_ALU, 3, 0);
        push_cycle("DECODE", 1'b1);
        if (op == 2'b10) begin
            begin_cycle();
            fld(P_REGSRC, 2, 1); fld(P_SRCA, 1, 0); fld(P_SRCB, 2, 1); fld(P_IMM, 2, 2);
            fld(P_ALU, 3, 0); fld(P_RES, 2, 2); fld(P_PCW, 1, int'(cex));
            push_cycle("BRANCH", 1'b1);
        end else if (op == 2'b01) begin
            begin_cycle();
            fld(P_SRCB, 2, 1); fld(P_IMM, 2, 1); fld(P_REGSRC, 2, 2);
            fld(P_ALU, 3, funct[3] ? 0 : 1);
            push_cycle("MEMADR", 1'b1);
            if (funct[0]) begin
                for (int i = 0; i < mwait; i++) begin
                    begin_cycle(); fld(P_ADR, 1, 1); push_cycle("MEMREAD-wait", 1'b0);
                end
                begin_cycle(); fld(P_ADR, 1, 1); push_cycle("MEMREAD", 1'b1);
                begin_cycle();
                fld(P_RES, 2, 1); fld(P_RW, 1, int'(cex)); fld(P_PCW, 1, int'(cex && rdpc));
                push_cycle("MEMWB", 1'b1);
            end else begin
                for (int i = 0; i < mwait; i++) begin
                    begin_cycle(); fld(P_ADR, 1, 1); fld(P_MW, 1, int'(cex));
                    push_cycle("MEMWRITE-wait", 1'b0);
                end
                begin_cycle(); fld(P_ADR, 1, 1); fld(P_MW, 1, int'(cex));
                push_cycle("MEMWRITE", 1'b1);
            end
        end else if (op == 2'b00) begin
            case (cmd)
                4'b0100: ctl = 0;
                4'b0010: ctl = 1;
                4'b1010: ctl = 1;
                4'b0000: ctl = 2;
                4'b1100: ctl = 3;
                4'b0001: ctl = 4;
                4'b1101: ctl = -1;
                default: begin ctl = 0; known = 1'b0; end
            endcase
            begin_cycle();
            fld(P_SRCA, 1, 0); fld(P_SRCB, 2, funct[5] ? 1 : 0);
            if (funct[5]) fld(P_IMM, 2, 0);
            if (ctl >= 0) fld(P_ALU, 3, ctl);
            fld(P_SHIFT, 1, int'(cmd == 4'b1101));
            push_cycle(funct[5] ? "EXECUTEI" : "EXECUTER", 1'b1);
            if (cex && known && (funct[0] || cmp)) m_flags = af;
            begin_cycle();
            fld(P_RES, 2, 0);
            fld(P_RW, 1, int'(cex && known && !cmp));
            fld(P_PCW, 1, int'(cex && known && !cmp && rdpc));
            push_cycle("ALUWB", 1'b1);
        end
    endfunction

    // ---------------- stimulus ----------------
    task automatic run(logic [31:0] ins, logic [3:0] af, int fwait, int mwait, int limit);
        cyc_t c;
        int   n = 0;
`ifndef CTRL_MEM_WAIT_EN
        fwait = 0;
        mwait = 0;
`endif
        model_instr(ins, af, fwait, mwait);
        instr     = ins;
        alu_flags = af;
        while (plan.size() > 0) begin
            c = plan.pop_front();
            if (n < limit) begin
                exp_q.push_back(c);
`ifdef CTRL_MEM_WAIT_EN
                mem_ready = c.rdy ? 1'b1 : 1'b0;
`endif
                @(posedge clk); #1;
            end
            n++;
        end
    endtask

    task automatic do_reset(int ncyc);
        reset   = 1'b0;
        m_flags = 4'h0;
        c_ins   = instr;
        for (int i = 0; i < ncyc; i++) begin
            begin_cycle(); fetch_fields(1'b0); push_cycle("RESET", 1'b1);
            exp_q.push_back(plan.pop_front());
            @(posedge clk); #1;
        end
        reset = 1'b1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [3:0] cond  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'he;
        logic [1:0] op    = 2'($urandom_range(0, 3));
        logic [5:0] funct = 6'($urandom_range(0, 63));
        logic [3:0] rd    = ($urandom_range(0, 4) == 0) ? 4'hf : 4'($urandom_range(0, 15));
        logic [3:0] cmds [7] = '{4'b0100, 4'b0010, 4'b1010, 4'b0000, 4'b1100, 4'b0001, 4'b1101};
        if (op == 2'b00 && $urandom_range(0, 4) != 0) funct[4:1] = cmds[$urandom_range(0, 6)];
        return {cond, op, funct, 4'($urandom_range(0, 15)), rd, 12'($urandom_range(0, 4095))};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            got = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, alu_src_a,
                   alu_src_b, imm_src, reg_src, alu_ctl, shift, carry, flags};
            n_checks++;
            if ((got & mon_e.msk) !== (mon_e.exp & mon_e.msk)) begin
                n_errors++;
                $display("FAIL %s instr=%h: got %h required %h (mask %h)",
                         mon_e.name, mon_e.ins, got, mon_e.exp, mon_e.msk);
            end
        end
    end

    initial begin
        @(posedge clk); #1;
        do_reset(2);
        // LDR, STR
        run(32'hE5901000, 4'h0, 0, 0, 1000);
        run(32'hE58B1000, 4'h0, 0, 0, 1000);
        // CMP r0,r0 -> Z, then BEQ taken and BNE not taken
        run(32'hE1500000, 4'b0100, 0, 0, 1000);
        run(32'h0A000002, 4'h0, 0, 0, 1000);
        run(32'h1A000002, 4'h0, 0, 0, 1000);
        // ADD (S=0) leaves flags, ADDS loads them, ADD rd=15 writes PC
        run(32'hE0800000, 4'b1001, 0, 0, 1000);
        run(32'hE0900000, 4'b1001, 0, 0, 1000);
        run(32'hE080F000, 4'b0110, 0, 0, 1000);
        // Reset abandons an LDR sitting in MEMREAD
        run(32'hE5901000, 4'h0, 0, 0, 3);
        do_reset(2);
        run(32'hE0900000, 4'b1111, 0, 0, 1000);
        // Held FETCH with memory not ready
        run(32'hE2800001, 4'h0, 3, 0, 1000);
        for (int i = 0; i < 200; i++) begin
            run(rand_instr(), 4'($urandom_range(0, 15)),
                $urandom_range(0, 2), $urandom_range(0, 2), 1000);
        end
        @(negedge clk); #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL queue-drain: got %0d pending required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
